// File: rtl/jt12_i2s_pkg.sv
// jt12_i2s_pkg: shared sample width, FIFO depth and stereo pair type for the I2S transmitter
package jt12_i2s_pkg;
  localparam int SAMPLE_W = 12;
  localparam int FIFO_DEPTH = 2;
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } pair_t;
endpackage

// File: rtl/jt12_i2s_fifo.sv
// jt12_i2s_fifo: 2-entry pair FIFO with occupancy and a one-cycle overrun pulse on dropped writes
module jt12_i2s_fifo
  import jt12_i2s_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr,
  input  pair_t      i_data,
  input  logic       i_rd,
  output pair_t      o_data,
  output logic       o_empty,
  output logic       o_overrun,
  output logic [1:0] o_level
);
  pair_t r_mem [FIFO_DEPTH];
  logic r_wp, r_rp, r_ov;
  logic [1:0] r_level;
  logic w_full, w_pop, w_push;
  assign o_empty = r_level == 2'd0;
  assign w_full = r_level == 2'd2;
  assign w_pop = i_rd & ~o_empty;
  // a full FIFO still accepts when the same cycle frees a slot
  assign w_push = i_wr & (~w_full | w_pop);
  assign o_data = r_mem[r_rp];
  assign o_overrun = r_ov;
  assign o_level = r_level;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_ov <= 1'b0;
      r_level <= 2'd0;
    end else begin
      r_wp <= r_wp ^ w_push;
      r_rp <= r_rp ^ w_pop;
      r_ov <= i_wr & ~w_push;
      r_level <= r_level + {1'b0, w_push} - {1'b0, w_pop};
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/jt12_i2s_tx.sv
// jt12_i2s_tx: captures accumulator pairs and serialises them on self-generated sclk/lrck.
// Define JT12_I2S_LJ_EN for left-justified output; default is standard I2S (one-bit delay).
module jt12_i2s_tx
  import jt12_i2s_pkg::*;
#(
  parameter int DIV = 4,
  parameter int WORD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] left,
  input  logic [11:0] right,
  input  logic        sample,
  output logic        sclk,
  output logic        lrck,
  output logic        sdata,
  output logic        overrun,
  output logic [1:0]  level
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int FW = 2 * WORD;
  localparam int BW = $clog2(FW);
  localparam int PAD = WORD - SAMPLE_W;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bcnt;
  logic [FW-1:0] r_sr;
  logic r_sample_d, r_sclk, r_lrck, r_lj;
  pair_t r_hold;
  pair_t w_head, w_pair;
  logic w_wr, w_tick, w_fall, w_bnd, w_empty;
  logic [WORD-1:0] w_lslot, w_rslot;
  logic [FW-1:0] w_frame;
  assign w_wr = sample & ~r_sample_d;
  assign w_tick = r_cnt == CW'(DIV - 1);
  assign w_fall = w_tick & r_sclk;
  assign w_bnd = w_fall & (r_bcnt == BW'(FW - 1));
  // an empty FIFO at the boundary repeats the last transmitted pair
  assign w_pair = w_empty ? r_hold : w_head;
  assign w_lslot = WORD'($unsigned(w_pair.left)) << PAD;
  assign w_rslot = WORD'($unsigned(w_pair.right)) << PAD;
  assign w_frame = {w_lslot, w_rslot};
  jt12_i2s_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .i_wr     (w_wr),
    .i_data   (pair_t'({left, right})),
    .i_rd     (w_bnd),
    .o_data   (w_head),
    .o_empty  (w_empty),
    .o_overrun(overrun),
    .o_level  (level)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sample_d <= 1'b0;
      r_cnt <= '0;
      r_sclk <= 1'b0;
      r_bcnt <= BW'(FW - 1);
      r_lrck <= 1'b1;
      r_sr <= '0;
      r_lj <= 1'b0;
      r_hold <= '0;
    end else begin
      r_sample_d <= sample;
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_sclk <= ~r_sclk;
      if (w_fall) begin
        r_bcnt <= w_bnd ? '0 : r_bcnt + BW'(1);
        r_sr <= w_bnd ? w_frame << 1 : r_sr << 1;
        r_lj <= w_bnd ? w_frame[FW-1] : r_sr[FW-1];
        r_lrck <= w_bnd ? 1'b0 : (r_bcnt == BW'(WORD - 1)) ? 1'b1 : r_lrck;
      end
      if (w_bnd) r_hold <= w_pair;
    end
  assign sclk = r_sclk;
  assign lrck = r_lrck;
`ifdef JT12_I2S_LJ_EN
  assign sdata = r_lj;
`else
  logic r_i2s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_i2s <= 1'b0;
    else if (w_fall) r_i2s <= r_lj;
  assign sdata = r_i2s;
`endif
endmodule

// File: tb/tb_jt12_i2s_tx.sv
// tb_jt12_i2s_tx: directed stimulus, per-cycle comparison against a frame-level model,
// plus literal frame contents for hand-computed pairs.
module tb_jt12_i2s_tx;
  localparam int DIV = 2;
  localparam int WORD = 16;
  localparam int FW = 2 * WORD;
`ifdef JT12_I2S_LJ_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, sample = 1'b0;
  logic [11:0] left = '0, right = '0;
  logic sclk, lrck, sdata, overrun;
  logic [1:0] level;
  int checks = 0, errors = 0;
  int n = 0, pre = 0, m = 0, p = 0;
  bit popped, wr;
  logic [23:0] q[$];
  logic [23:0] cur = '0, prev = '0;
  logic samp_prev = 1'b0, ov_exp = 1'b0;
  logic e_sclk, e_lrck, e_sd;
  logic [FW-1:0] cap = '0;
  logic [FW-1:0] frames[$];

  jt12_i2s_tx #(.DIV(DIV), .WORD(WORD)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .sample(sample),
    .sclk(sclk), .lrck(lrck), .sdata(sdata), .overrun(overrun), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at n=%0d", name, act, exp, n);
    end
  endtask

  // bit p of a frame: left sample MSB-first then padding, then right likewise
  function automatic logic bitval(input logic [23:0] pr, input int b);
    if (b < WORD) return (b < 12) ? pr[23-b] : 1'b0;
    return (b - WORD < 12) ? pr[11-(b-WORD)] : 1'b0;
  endfunction

  function automatic logic [31:0] fx(input logic [31:0] v);
    return LJ ? v : v >> 1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      n = 0; q.delete(); cur = '0; prev = '0; samp_prev = 1'b0; ov_exp = 1'b0; frames.delete();
    end else begin
      n++;
      wr = sample && !samp_prev;
      samp_prev = sample;
      ov_exp = 1'b0;
      popped = 1'b0;
      pre = q.size();
      if (n % (2*DIV) == 0 && ((n / (2*DIV)) - 1) % FW == 0) begin
        prev = cur;
        popped = pre > 0;
        if (popped) cur = q.pop_front();
      end
      if (wr) begin
        if (pre < 2 || popped) q.push_back({left, right});
        else ov_exp = 1'b1;
      end
    end
    #1;
    e_sclk = ((n / DIV) % 2) == 1;
    if (n < 2*DIV) begin
      e_lrck = 1'b1;
      e_sd = 1'b0;
    end else begin
      m = n / (2*DIV);
      p = (m - 1) % FW;
      e_lrck = p >= WORD;
      e_sd = LJ ? bitval(cur, p) : (p == 0 ? bitval(prev, FW-1) : bitval(cur, p-1));
    end
    chk("sclk", 32'(sclk), 32'(e_sclk));
    chk("lrck", 32'(lrck), 32'(e_lrck));
    chk("sdata", 32'(sdata), 32'(e_sd));
    chk("overrun", 32'(overrun), 32'(ov_exp));
    chk("level", 32'(level), 32'(q.size()));
    if (rst && n >= 2*DIV && n % (2*DIV) == 0) begin
      cap = {cap[FW-2:0], sdata};
      if (p == FW - 1) frames.push_back(cap);
    end
  end

  task automatic wait_n(input int t);
    int g = 0;
    while (n < t && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (n < t) begin
      checks++;
      errors++;
      $display("FAIL wait_n: reached n=%0d required %0d", n, t);
    end
  endtask

  task automatic edge_at(input int k, input logic [11:0] l, input logic [11:0] r);
    wait_n(k - 1);
    left = l;
    right = r;
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_lrck", 32'(lrck), 32'd1);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    edge_at(50, 12'h801, 12'h7FF);
    chk("lvl_one", 32'(level), 32'd1);
    wait_n(384);
    chk("f0_zero", frames[0], 32'h0);
    chk("f1_pair", frames[1], fx(32'h80107FF0));
    chk("f2_hold", frames[2], fx(32'h80107FF0));
    edge_at(400, 12'h123, 12'h456);
    chk("lvl_a", 32'(level), 32'd1);
    edge_at(420, 12'hABC, 12'hDEF);
    chk("lvl_b", 32'(level), 32'd2);
    edge_at(440, 12'h555, 12'hAAA);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_lvl", 32'(level), 32'd2);
    @(negedge clk);
    chk("ovr_clear", 32'(overrun), 32'd0);
    edge_at(800, 12'h001, 12'hFFF);
    edge_at(820, 12'h7FF, 12'h800);
    chk("lvl_de", 32'(level), 32'd2);
    edge_at(900, 12'h5A5, 12'hA5A);
    chk("bnd_noovr", 32'(overrun), 32'd0);
    chk("bnd_lvl", 32'(level), 32'd2);
    edge_at(1416, 12'h3C3, 12'h3C3);
    chk("lvl_g", 32'(level), 32'd1);
    chk("nframes", 32'(frames.size()), 32'd11);
    chk("f4_a", frames[4], fx(32'h12304560));
    chk("f5_b", frames[5], fx(32'hABC0DEF0));
    chk("f6_bhold", frames[6], fx(32'hABC0DEF0));
    chk("f7_d", frames[7], fx(32'h0010FFF0));
    chk("f8_e", frames[8], fx(32'h7FF08000));
    chk("f9_f", frames[9], fx(32'h5A50A5A0));
    chk("f10_fhold", frames[10], fx(32'h5A50A5A0));
    wait_n(1430);
    #3 rst = 1'b0;
    #1;
    chk("arst_sclk", 32'(sclk), 32'd0);
    chk("arst_lrck", 32'(lrck), 32'd1);
    chk("arst_sdata", 32'(sdata), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_n(260);
    chk("post_nframes", 32'(frames.size()), 32'd2);
    chk("post_f0", frames[0], 32'h0);
    chk("post_f1", frames[1], 32'h0);
    chk("post_level", 32'(level), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt12_i2s_tx.md
# jt12_i2s_tx

Serial audio transmitter that sits directly downstream of the channel accumulator. It captures each new 12-bit signed left/right pair on the rising edge of the accumulator's `sample` level and buffers it in a 2-entry FIFO. It then shifts the pair out MSB-first on a self-generated bit clock / word clock, feeding an external I2S DAC.

## Interface
Parameters:
- DIV, 4, clk cycles per sclk half-period; ≥1
- WORD, 16, sclk cycles per channel slot; 12..32

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- left  in  12  signed left sample from accumulator
- right  in  12  signed right sample from accumulator
- sample  in  1  accumulator sample level; a 0→1 transition marks left/right valid
- sclk  out  1  bit clock
- lrck  out  1  word clock; 0 = left slot, 1 = right slot
- sdata  out  1  serial data
- overrun  out  1  one-cycle pulse when a captured pair is dropped because the FIFO is full
- level  out  2  FIFO occupancy, 0..2

## Operation
- Edge detect: `sample` is registered as `sample_d`. Write request `wr = sample & ~sample_d`. Pair `{left,right}` is sampled in the same cycle `wr` is computed.
- FIFO: 2 entries × 24 bits.
  - `wr` with level<2 → store the pair.
  - `wr` with level==2 and no read in that cycle → drop the new pair, pulse overrun.
  - `wr` and read in the same cycle with level==2 → accepted, no overrun.
  - Read on empty → no pop; the hold register (last transmitted pair) is reused.
  - `wr` and read in the same cycle on empty → write accepted, read returns the hold value (no bypass).
- Divider: `cnt` counts 0..DIV-1. At cnt==DIV-1, sclk toggles and cnt wraps to 0.
- Bit counter `bcnt` counts 0..2*WORD-1 and advances on each sclk falling edge (sclk 1→0).
- Frame boundary is a falling edge where `bcnt` wraps to 0. At the frame boundary:
  - Read the FIFO (or use the hold register).
  - Load the 2*WORD shift register with {L[11:0], (WORD-12) zeros, R[11:0], (WORD-12) zeros}.
  - Drive lrck to 0.
- lrck goes to 1 on the falling edge where bcnt becomes WORD.
- sdata updates only on sclk falling edges and is stable across the rising edge.
- Samples are not re-scaled or saturated. Zero padding makes them left-justified within the slot.

## Timing
- Reset values: sclk=0, lrck=1, sdata=0, overrun=0, level=0, cnt=0, bcnt=2*WORD-1, hold=0, sample_d=0.
- First sclk rise occurs at clk edge DIV after reset release. The first fall, which is the first frame boundary, occurs at edge 2*DIV. That first frame transmits the hold value (zeros) unless a pair was written earlier.
- Frame period is 4*DIV*WORD clk cycles.
- Capture latency: `sample` rises in cycle t → pair in FIFO at edge t+1 → transmitted starting at the next frame boundary after t+1.
- Reset asserted mid-frame forces all reset values immediately. The FIFO is emptied and any partial frame is abandoned.
- overrun is high for exactly one clk cycle per dropped pair.

## Configuration
- JT12_I2S_LJ_EN defined: left-justified format. The MSB of the left sample appears on sdata at the same falling edge on which lrck goes to 0.
- Not defined (default): standard I2S. sdata passes through a 1-bit register clocked on sclk falling edges, so each bit appears one sclk period after it would in LJ mode. The left MSB appears on the falling edge after lrck goes to 0. The bit shown at the boundary is the last bit of the previous right slot.
- lrck timing is identical in both modes.

## Structure
- Package jt12_i2s_pkg holds:
  - SAMPLE_W=12
  - FIFO_DEPTH=2
  - the pair type `{left,right}` (24 bits)
- Sub-module jt12_i2s_fifo holds the 2-entry FIFO with level, full/empty and the overrun decision. The top level keeps the edge detect, divider, counters, shift register and format delay.

## Test plan
- Reset, no sample edges, DIV=2, WORD=16: sclk period 4 clks; lrck period 128 clks; sdata constantly 0; level=0.
- left=12'h801, right=12'h7FF, one sample rising edge, LJ mode: next left slot reads 1000_0000_0001_0000; right slot reads 0111_1111_1111_0000; lrck 0 then 1.
- Same stimulus in I2S mode: identical bit sequence delayed by one sclk relative to lrck; the bit at the left-slot boundary equals the previous right-slot final bit (0).
- Three sample edges between two frame boundaries: level 1→2, third edge pulses overrun for 1 clk, the first two pairs transmit in order, and the third pair is never seen.
- Sample edge coinciding with a frame-boundary read at level==2: no overrun, level stays 2. One edge after an empty FIFO: the hold pair is repeated in the following frames until a new pair arrives.
- rst pulled low mid-left-slot: sclk=0, lrck=1, sdata=0, level=0 asynchronously. After release, the first frame boundary occurs 2*DIV clks later and transmits zeros.
